// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: DRP master that read-modify-writes one of two register tables into a running MMCM.
// Ports: i_dclk/i_rst clock and sync reset; i_sen/i_saddr start pulse and table select;
//        o_srdy done pulse, o_busy in progress, o_err sticky timeout;
//        o_daddr/o_di/o_den/o_dwe/i_do/i_drdy DRP port; i_locked and o_rst_mmcm MMCM lock and reset.
module mmcm_drp_reconfig #(
    parameter int                     NUM_REGS     = 23,
    parameter logic [NUM_REGS*39-1:0] CFG0_TABLE   = '0,
    parameter logic [NUM_REGS*39-1:0] CFG1_TABLE   = '0,
    parameter int                     DRDY_TIMEOUT = 1023,
    parameter int                     LOCK_TIMEOUT = 65535
) (
    input  logic        i_dclk,
    input  logic        i_rst,
    input  logic        i_sen,
    input  logic        i_saddr,
    output logic        o_srdy,
    output logic        o_busy,
    output logic        o_err,
    output logic [6:0]  o_daddr,
    output logic [15:0] o_di,
    output logic        o_den,
    output logic        o_dwe,
    input  logic [15:0] i_do,
    input  logic        i_drdy,
    input  logic        i_locked,
    output logic        o_rst_mmcm
);
    localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 3);

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_READ, S_WAIT_RD, S_MODIFY, S_WRITE, S_WAIT_WR, S_WAIT_LOCK
    } state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_idx, w_idx;
    logic          r_sel, w_sel;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_do_cap, r_di;
    logic [6:0]    r_daddr;
    logic          r_srdy, r_busy, r_err, r_den, r_dwe, r_rst_mmcm;
    logic [38:0]   w_entry;
    logic [15:0]   w_mask, w_data;
    logic          w_accept, w_last, w_ok, w_to;
    logic          w_busy, w_err, w_den, w_dwe, w_rst_mmcm;

    assign w_accept = (r_state == S_IDLE) && i_sen;
    assign w_last   = r_idx == IW'(NUM_REGS - 1);
    // Table index and select as they will be next cycle, so DADDR is registered for the entry being accessed.
    assign w_sel    = w_accept ? i_saddr : r_sel;
    assign w_idx    = w_accept ? '0 : (r_state == S_WAIT_WR && i_drdy && !w_last) ? r_idx + 1'b1 : r_idx;
    assign w_entry  = w_sel ? CFG1_TABLE[w_idx*39 +: 39] : CFG0_TABLE[w_idx*39 +: 39];
    assign w_mask   = w_entry[31:16];
    assign w_data   = w_entry[15:0];

    always_ff @(posedge i_dclk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_sel      <= 1'b0;
            r_cnt      <= '0;
            r_do_cap   <= '0;
            r_di       <= '0;
            r_daddr    <= '0;
            r_srdy     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_rst_mmcm <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_idx;
            r_sel      <= w_sel;
            // Restarting on every state change also restarts it on each DEN and on entry to WAIT_LOCK.
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == S_WAIT_RD && i_drdy)
                r_do_cap <= i_do;
            if (r_state == S_MODIFY)
                r_di <= (r_do_cap & w_mask) | (w_data & ~w_mask);
            if (w_den)
                r_daddr <= w_entry[38:32];
            r_srdy     <= w_ok;
            r_busy     <= w_busy;
            r_err      <= w_err;
            r_den      <= w_den;
            r_dwe      <= w_dwe;
            r_rst_mmcm <= w_rst_mmcm;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ok   = 1'b0;
        w_to   = 1'b0;
        case (r_state)
            S_IDLE:      w_next = i_sen ? S_ASSERT : S_IDLE;
            S_ASSERT:    w_next = S_READ;
            S_READ:      w_next = S_WAIT_RD;
            S_WAIT_RD: begin
                w_to   = !i_drdy && r_cnt == CW'(DRDY_TIMEOUT - 1);
                w_next = i_drdy ? S_MODIFY : w_to ? S_IDLE : S_WAIT_RD;
            end
            S_MODIFY:    w_next = S_WRITE;
            S_WRITE:     w_next = S_WAIT_WR;
            S_WAIT_WR: begin
                w_to   = !i_drdy && r_cnt == CW'(DRDY_TIMEOUT - 1);
                w_next = i_drdy ? (w_last ? S_WAIT_LOCK : S_READ) : w_to ? S_IDLE : S_WAIT_WR;
            end
            S_WAIT_LOCK: begin
                // The first two cycles ignore LOCKED so a lock left over from before reset is not trusted.
                w_ok   = i_locked && r_cnt >= CW'(2);
                w_to   = !w_ok && r_cnt == CW'(LOCK_TIMEOUT - 1);
                w_next = (w_ok || w_to) ? S_IDLE : S_WAIT_LOCK;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = w_next != S_IDLE;
        w_rst_mmcm = w_next != S_IDLE && w_next != S_WAIT_LOCK;
        w_den      = w_next == S_READ || w_next == S_WRITE;
        w_dwe      = w_next == S_WRITE;
        w_err      = w_to || (r_err && !w_accept);
    end

    assign o_srdy     = r_srdy;
    assign o_busy     = r_busy;
    assign o_err      = r_err;
    assign o_daddr    = r_daddr;
    assign o_di       = r_di;
    assign o_den      = r_den;
    assign o_dwe      = r_dwe;
    assign o_rst_mmcm = r_rst_mmcm;
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: randomized bench for mmcm_drp_reconfig with a DRP/MMCM model and table-level expectations.
module tb_mmcm_drp_reconfig;
    localparam int NR = 2;
    localparam int DT = 20;
    localparam int LT = 40;
    localparam logic [NR*39-1:0] T0 = {7'h14, 16'h00FF, 16'h1234, 7'h08, 16'hF000, 16'h0041};
    localparam logic [NR*39-1:0] T1 = {7'h4F, 16'hFFF0, 16'h0005, 7'h4E, 16'h0F0F, 16'hABCD};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sen = 1'b0;
    logic        saddr = 1'b0;
    logic        srdy, busy, err, den, dwe, rst_mmcm;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;
    logic        locked;

    int total = 0, bad = 0, cyc = 0;
    int lat = 1, drop_idx = -1, acc_n = 0, cd = 0, lock_mode = 0, lock_dly = 0, lk = -1;
    int srdy_n = 0, srdy_cyc = -1, fall_cyc = -1, done_cyc = 0;
    int multi_bad = 0, dwe_bad = 0, srdy_busy_bad = 0;
    bit out_pend = 0, prm = 0, pw = 0;
    logic [6:0]  pa;
    logic [15:0] pd;
    logic [15:0] mem [128];
    logic [6:0]  la[$], ea[$];
    bit          lw[$], ew[$];
    logic [15:0] ld[$], ed[$];
    int          lc[$];

    mmcm_drp_reconfig #(
        .NUM_REGS(NR), .CFG0_TABLE(T0), .CFG1_TABLE(T1), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
    ) dut (
        .i_dclk(clk), .i_rst(rst), .i_sen(sen), .i_saddr(saddr),
        .o_srdy(srdy), .o_busy(busy), .o_err(err),
        .o_daddr(daddr), .o_di(di), .o_den(den), .o_dwe(dwe),
        .i_do(drp_do), .i_drdy(drdy), .i_locked(locked), .o_rst_mmcm(rst_mmcm)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DRP slave: logs every access, answers after lat cycles from a register-file model.
    initial begin
        drdy = 1'b0;
        drp_do = '0;
        forever begin
            @(negedge clk);
            drdy = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drdy = 1'b1;
                    out_pend = 0;
                    if (pw) begin
                        mem[pa] = pd;
                        drp_do = 16'h0;
                    end else
                        drp_do = mem[pa];
                end
            end
            if (den === 1'b1) begin
                if (out_pend) multi_bad++;
                la.push_back(daddr);
                lw.push_back(dwe);
                ld.push_back(di);
                lc.push_back(cyc);
                if (acc_n != drop_idx) begin
                    cd = lat;
                    pa = daddr;
                    pw = dwe;
                    pd = di;
                end
                out_pend = 1;
                acc_n++;
            end
        end
    end

    // MMCM model: unlocked while in reset, locks lock_dly cycles after reset falls.
    initial begin
        locked = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_mmcm === 1'b1) lk = -1;
            else if (prm) begin
                lk = 0;
                fall_cyc = cyc;
            end else if (lk >= 0) lk++;
            prm = (rst_mmcm === 1'b1);
            if (lock_mode == 1) locked = 1'b1;
            else if (lock_mode == 2) locked = 1'b0;
            else if (rst_mmcm === 1'b1) locked = 1'b0;
            else if (lk >= 0 && lk >= lock_dly) locked = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (srdy === 1'b1) begin
            srdy_n++;
            srdy_cyc = cyc;
            if (busy !== 1'b0) srdy_busy_bad++;
        end
        if (dwe === 1'b1 && den !== 1'b1) dwe_bad++;
    end

    function automatic logic [38:0] ent(input bit sel, input int i);
        logic [NR*39-1:0] t;
        t = sel ? T1 : T0;
        return t[i*39 +: 39];
    endfunction

    // Expected access sequence: read then masked write for each table entry, in table order.
    task automatic build_exp(input bit sel);
        logic [15:0] mm [128];
        logic [38:0] e;
        logic [15:0] w;
        mm = mem;
        ea.delete(); ew.delete(); ed.delete();
        for (int i = 0; i < NR; i++) begin
            e = ent(sel, i);
            w = (mm[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
            mm[e[38:32]] = w;
            ea.push_back(e[38:32]); ew.push_back(1'b0); ed.push_back(16'h0);
            ea.push_back(e[38:32]); ew.push_back(1'b1); ed.push_back(w);
        end
    endtask

    task automatic prep();
        la.delete(); lw.delete(); ld.delete(); lc.delete();
        acc_n = 0; srdy_n = 0; srdy_cyc = -1; fall_cyc = -1; drop_idx = -1;
        multi_bad = 0; dwe_bad = 0; srdy_busy_bad = 0; out_pend = 0;
    endtask

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 128; a++)
            mem[a] = (mode == 0) ? 16'h0000 : (mode == 1) ? 16'hFFFF : 16'($urandom);
    endtask

    task automatic pulse_sen(input bit sel);
        @(posedge clk); #1;
        sen = 1'b1; saddr = sel;
        @(posedge clk); #1;
        sen = 1'b0; saddr = ~sel;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < budget);
        to = (busy !== 1'b0);
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; sen = 1'b1; saddr = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (srdy !== 1'b0) begin bad++; $display("FAIL reset_srdy got=%b exp=0", srdy); end
        total++; if ({den, dwe} !== 2'b00) begin bad++; $display("FAIL reset_den_dwe got=%b exp=00", {den, dwe}); end
        total++; if (rst_mmcm !== 1'b0) begin bad++; $display("FAIL reset_rst_mmcm got=%b exp=0", rst_mmcm); end
        total++; if ({daddr, di} !== 23'h0) begin bad++; $display("FAIL reset_daddr_di got=%h/%h exp=0/0", daddr, di); end
        @(posedge clk); #1;
        rst = 1'b0; sen = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_sen_dropped busy got=%b exp=0", busy); end
    endtask

    task automatic test_cfg0();
        bit to;
        prep(); fill_mem(1); lat = 3; lock_mode = 0; lock_dly = 10;
        build_exp(1'b0);
        pulse_sen(1'b0);
        @(negedge clk);
        total++; if ({busy, rst_mmcm, den} !== 3'b110) begin bad++; $display("FAIL cfg0_cycle1 busy/rst/den got=%b exp=110", {busy, rst_mmcm, den}); end
        @(negedge clk);
        total++; if ({den, dwe, daddr} !== {2'b10, 7'h08}) begin bad++; $display("FAIL cfg0_cycle2 den/dwe/daddr got=%b%b/%h exp=10/08", den, dwe, daddr); end
        wait_idle(300, to);
        total++; if (to) begin bad++; $display("FAIL cfg0_done_timeout busy got=%b exp=0", busy); end
        total++; if (ld.size() < 2 || ld[1] !== 16'hF041 || la[1] !== 7'h08) begin bad++; $display("FAIL cfg0_first_write got=%0d accesses exp a=08 di=F041", ld.size()); end
        total++; if (la.size() != ea.size()) begin bad++; $display("FAIL cfg0_count got=%0d exp=%0d", la.size(), ea.size()); end
        for (int i = 0; i < la.size() && i < ea.size(); i++) begin
            total++;
            if (la[i] !== ea[i] || lw[i] !== ew[i] || (ew[i] && ld[i] !== ed[i])) begin
                bad++; $display("FAIL cfg0_acc%0d got a=%h we=%0d di=%h exp a=%h we=%0d di=%h", i, la[i], lw[i], ld[i], ea[i], ew[i], ed[i]);
            end
        end
        total++; if (srdy_n != 1 || srdy_busy_bad != 0) begin bad++; $display("FAIL cfg0_srdy pulses=%0d busy_high=%0d exp 1/0", srdy_n, srdy_busy_bad); end
        total++; if (srdy_cyc - fall_cyc != 11) begin bad++; $display("FAIL cfg0_lock_latency got=%0d exp=11", srdy_cyc - fall_cyc); end
        total++; if (done_cyc != srdy_cyc) begin bad++; $display("FAIL cfg0_busy_fall got=%0d exp=%0d", done_cyc, srdy_cyc); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL cfg0_err got=%b exp=0", err); end
    endtask

    task automatic test_cfg1();
        bit to;
        prep(); fill_mem(0); lat = $urandom_range(1, 4); lock_mode = 0; lock_dly = 4;
        build_exp(1'b1);
        pulse_sen(1'b1);
        wait_idle(300, to);
        total++; if (to) begin bad++; $display("FAIL cfg1_done_timeout busy got=%b exp=0", busy); end
        total++; if (la.size() != 2 * NR) begin bad++; $display("FAIL cfg1_den_count got=%0d exp=%0d", la.size(), 2 * NR); end
        for (int i = 0; i < la.size() && i < ea.size(); i++) begin
            total++;
            if (la[i] !== ea[i] || lw[i] !== ew[i] || (ew[i] && ld[i] !== ed[i])) begin
                bad++; $display("FAIL cfg1_acc%0d got a=%h we=%0d di=%h exp a=%h we=%0d di=%h", i, la[i], lw[i], ld[i], ea[i], ew[i], ed[i]);
            end
        end
        total++; if (srdy_n != 1) begin bad++; $display("FAIL cfg1_srdy got=%0d exp=1", srdy_n); end
    endtask

    task automatic test_drdy_timeout();
        bit to;
        int dc;
        prep(); fill_mem(2); lat = 2; lock_mode = 0; lock_dly = 3; drop_idx = 2;
        pulse_sen(1'b0);
        wait_idle(300, to);
        dc = (lc.size() >= 3) ? done_cyc - lc[2] : -1;
        total++; if (to) begin bad++; $display("FAIL drdy_to_hang busy got=%b exp=0", busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL drdy_to_err got=%b exp=1", err); end
        total++; if (rst_mmcm !== 1'b0 || srdy_n != 0) begin bad++; $display("FAIL drdy_to_state rst_mmcm=%b srdy=%0d exp 0/0", rst_mmcm, srdy_n); end
        total++; if (la.size() != 3) begin bad++; $display("FAIL drdy_to_count got=%0d exp=3", la.size()); end
        total++; if (dc < DT || dc > DT + 2) begin bad++; $display("FAIL drdy_to_delay got=%0d exp=%0d..%0d", dc, DT, DT + 2); end
        prep();
        pulse_sen(1'b0);
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL drdy_to_clear got=%b exp=0", err); end
        wait_idle(300, to);
        total++; if (to || srdy_n != 1 || err !== 1'b0) begin bad++; $display("FAIL drdy_to_recover to=%0d srdy=%0d err=%b exp 0/1/0", to, srdy_n, err); end
    endtask

    task automatic test_sen_ignored();
        bit to;
        bit sel;
        sel = 1'($urandom);
        prep(); fill_mem(2); lat = 3; lock_mode = 0; lock_dly = 2;
        build_exp(sel);
        pulse_sen(sel);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        sen = 1'b1; saddr = ~sel;
        @(posedge clk); #1;
        sen = 1'b0;
        wait_idle(300, to);
        total++; if (to || la.size() != ea.size()) begin bad++; $display("FAIL sen_ign_count got=%0d exp=%0d", la.size(), ea.size()); end
        for (int i = 0; i < la.size() && i < ea.size(); i++) begin
            total++;
            if (la[i] !== ea[i] || lw[i] !== ew[i] || (ew[i] && ld[i] !== ed[i])) begin
                bad++; $display("FAIL sen_ign_acc%0d got a=%h we=%0d di=%h exp a=%h we=%0d di=%h", i, la[i], lw[i], ld[i], ea[i], ew[i], ed[i]);
            end
        end
        total++; if (srdy_n != 1 || multi_bad != 0) begin bad++; $display("FAIL sen_ign_srdy got=%0d overlap=%0d exp 1/0", srdy_n, multi_bad); end
    endtask

    task automatic test_rst_mid();
        bit found = 0;
        int n0;
        prep(); fill_mem(2); lat = 2; lock_mode = 0; lock_dly = 2;
        pulse_sen(1'b1);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (den === 1'b1 && dwe === 1'b1);
        end
        total++; if (!found) begin bad++; $display("FAIL rst_mid_no_write got=0 exp=1"); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if ({den, rst_mmcm, busy} !== 3'b000) begin bad++; $display("FAIL rst_mid_state den/rst/busy got=%b exp=000", {den, rst_mmcm, busy}); end
        n0 = acc_n;
        repeat (30) @(negedge clk);
        total++; if (acc_n != n0 || srdy_n != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet accesses=%0d srdy=%0d exp=%0d/0", acc_n, srdy_n, n0); end
    endtask

    task automatic test_lock();
        bit to;
        prep(); fill_mem(2); lat = 1; lock_mode = 1;
        pulse_sen(1'($urandom));
        wait_idle(300, to);
        total++; if (to || srdy_n != 1) begin bad++; $display("FAIL lock_held_srdy got=%0d exp=1", srdy_n); end
        total++; if (srdy_cyc - fall_cyc != 3) begin bad++; $display("FAIL lock_held_blank got=%0d exp=3", srdy_cyc - fall_cyc); end
        prep(); lock_mode = 2;
        pulse_sen(1'($urandom));
        wait_idle(400, to);
        total++; if (to || err !== 1'b1 || srdy_n != 0) begin bad++; $display("FAIL lock_to_err err=%b srdy=%0d exp 1/0", err, srdy_n); end
        total++; if (done_cyc - fall_cyc < LT - 1 || done_cyc - fall_cyc > LT + 1) begin bad++; $display("FAIL lock_to_delay got=%0d exp=%0d", done_cyc - fall_cyc, LT); end
        lock_mode = 0;
    endtask

    task automatic test_random();
        bit to;
        bit sel;
        int exp_gap;
        for (int it = 0; it < 6; it++) begin
            sel = 1'($urandom);
            prep(); fill_mem(2); lat = $urandom_range(1, 4); lock_mode = 0; lock_dly = $urandom_range(0, 12);
            exp_gap = ((lock_dly > 2) ? lock_dly : 2) + 1;
            build_exp(sel);
            pulse_sen(sel);
            wait_idle(300, to);
            total++; if (to || la.size() != ea.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, la.size(), ea.size()); end
            for (int i = 0; i < la.size() && i < ea.size(); i++) begin
                total++;
                if (la[i] !== ea[i] || lw[i] !== ew[i] || (ew[i] && ld[i] !== ed[i])) begin
                    bad++; $display("FAIL rnd%0d_acc%0d got a=%h we=%0d di=%h exp a=%h we=%0d di=%h", it, i, la[i], lw[i], ld[i], ea[i], ew[i], ed[i]);
                end
            end
            total++; if (srdy_n != 1 || err !== 1'b0) begin bad++; $display("FAIL rnd%0d_srdy got=%0d err=%b exp 1/0", it, srdy_n, err); end
            total++; if (srdy_cyc - fall_cyc != exp_gap) begin bad++; $display("FAIL rnd%0d_lock_gap got=%0d exp=%0d", it, srdy_cyc - fall_cyc, exp_gap); end
            total++; if (multi_bad != 0 || dwe_bad != 0) begin bad++; $display("FAIL rnd%0d_protocol overlap=%0d stray_dwe=%0d exp 0/0", it, multi_bad, dwe_bad); end
        end
    endtask

    initial begin
        fill_mem(0);
        test_reset();
        test_cfg0();
        test_cfg1();
        test_drdy_timeout();
        test_sen_ignored();
        test_rst_mid();
        test_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
